// File: rtl/btn_debounce_bank.sv
// N-channel button conditioner: two-flop synchroniser, stability-window debounce,
// registered press/release strobes and tick-paced auto-repeat. The release strobe
// port is named release_o because `release` is a reserved word.

module btn_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DAS_TICKS       = 10,
    parameter int ARR_TICKS       = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_in,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic release_o,
    output logic rpt,
    output logic cmd
);
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (DAS_TICKS > ARR_TICKS) ? DAS_TICKS : ARR_TICKS;
    localparam int RC_W    = $clog2(RPT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [RC_W-1:0]  DAS_MAX = RC_W'(DAS_TICKS);
    localparam logic [RC_W-1:0]  ARR_MAX = RC_W'(ARR_TICKS);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_e;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             rpt_q, rpt_d;
    logic             cmd_q, cmd_d;
    rpt_state_e       state_q, state_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic [RC_W-1:0]  rc_inc;

    // Synchroniser and debounce window
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
            // Commit on the edge the window fills so the level lands at sample+DEBOUNCE_CYCLES+2.
            if (cnt_d == CNT_MAX) begin
                level_d = cand_q;
            end
        end else begin
            level_d = cand_q;
        end
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
    end

    // Repeat FSM: arms on the registered press, so a tick in the press cycle is never counted.
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        rpt_d   = 1'b0;
        rc_inc  = rc_q + 1'b1;
        if (!repeat_en || !level_q || !level_d) begin
            state_d = IDLE;
            rc_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press_q) begin
                        state_d = DELAY;
                        rc_d    = '0;
                    end
                end
                DELAY: begin
                    if (tick) begin
                        if (rc_inc == DAS_MAX) begin
                            rpt_d   = 1'b1;
                            rc_d    = '0;
                            state_d = REPEAT;
                        end else begin
                            rc_d = rc_inc;
                        end
                    end
                end
                REPEAT: begin
                    if (tick) begin
                        if (rc_inc == ARR_MAX) begin
                            rpt_d = 1'b1;
                            rc_d  = '0;
                        end else begin
                            rc_d = rc_inc;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    rc_d    = '0;
                end
            endcase
        end
        cmd_d = press_d | rpt_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cand_q    <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rpt_q     <= 1'b0;
            cmd_q     <= 1'b0;
            state_q   <= IDLE;
            rc_q      <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            rpt_q     <= rpt_d;
            cmd_q     <= cmd_d;
            state_q   <= state_d;
            rc_q      <= rc_d;
        end
    end

    assign level     = level_q;
    assign press     = press_q;
    assign release_o = release_q;
    assign rpt       = rpt_q;
    assign cmd       = cmd_q;
endmodule

module btn_debounce_bank #(
    parameter int N_CH            = 5,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DAS_TICKS       = 10,
    parameter int ARR_TICKS       = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] rpt,
    output logic [N_CH-1:0] cmd
);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .DAS_TICKS      (DAS_TICKS),
            .ARR_TICKS      (ARR_TICKS)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick),
            .btn_in   (btn_in[i]),
            .repeat_en(repeat_en[i]),
            .level    (level[i]),
            .press    (press[i]),
            .release_o(release_o[i]),
            .rpt      (rpt[i]),
            .cmd      (cmd[i])
        );
    end
endmodule
